// File: rtl/riscv_defines.sv
// Shared definitions for the RV32M multiply/divide unit.
//   WORD_WIDTH    : operand/result width
//   MDU_OP_WIDTH  : width of the MDU operation code
//   MDU_*         : operation codes (funct3 encoding of the M extension)
//   mdu_state_t   : control states of the MDU
//   DIV_CYCLES    : number of restoring-divide iterations
package riscv_defines;

    localparam int WORD_WIDTH   = 32;
    localparam int MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'b000;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'b001;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'b010;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'b011;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'b100;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'b101;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'b110;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'b111;

    localparam int DIV_CYCLES = WORD_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/riscv_mdu_div_step.sv
// One iteration of an unsigned restoring divider.
//   rem       : partial remainder (always < divisor)
//   quo       : dividend bits still to be shifted in / quotient bits so far
//   divisor   : divisor magnitude (non-zero)
//   rem_next  : partial remainder after this iteration
//   quo_next  : quotient register after this iteration
module riscv_mdu_div_step
    import riscv_defines::*;
(
    input  logic [WORD_WIDTH-1:0] rem,
    input  logic [WORD_WIDTH-1:0] quo,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic [WORD_WIDTH-1:0] rem_next,
    output logic [WORD_WIDTH-1:0] quo_next
);

    logic [WORD_WIDTH:0] shifted;
    logic [WORD_WIDTH:0] diff;
    logic                ge;

    // The shifted remainder can reach 2*divisor-1, so one extra bit is kept;
    // a clear borrow bit means the trial subtraction succeeded.
    always_comb begin
        shifted  = {rem, quo[WORD_WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        ge       = ~diff[WORD_WIDTH];
        rem_next = ge ? diff[WORD_WIDTH-1:0] : shifted[WORD_WIDTH-1:0];
        quo_next = {quo[WORD_WIDTH-2:0], ge};
    end

endmodule

// File: rtl/riscv_mdu.sv
// RV32M execution-stage multiply/divide responder.
//   clk, rst_n      : clock, asynchronous active-low reset
//   op_valid_i      : request valid;  op_ready_o high while idle
//   mdu_op_i        : operation code (MDU_*)
//   operand_a_i/b_i : rs1 / rs2 values
//   kill_i          : synchronous abort, drops any operation in flight
//   result_valid_o  : result available; result_ready_i consumes it
//   result_o        : registered result, stable while result_valid_o is high
// Multiplies take one compute cycle; divides run a 32-step restoring divider
// followed by a sign-fix cycle. Divide-by-zero and signed overflow finish
// at the accept edge.
module riscv_mdu
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
    input  logic [WORD_WIDTH-1:0]   operand_a_i,
    input  logic [WORD_WIDTH-1:0]   operand_b_i,
    input  logic                    kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [WORD_WIDTH-1:0]   result_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    mdu_state_t state_q, state_d;

    logic [MDU_OP_WIDTH-1:0] op_q;
    logic [WORD_WIDTH-1:0]   a_q;
    logic [WORD_WIDTH-1:0]   b_q;
    logic [WORD_WIDTH-1:0]   rem_q;
    logic [WORD_WIDTH-1:0]   quo_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    sign_a_q;
    logic                    sign_b_q;
    logic [WORD_WIDTH-1:0]   result_q;

    logic                    accept;
    logic                    is_div_op;
    logic                    is_signed_div;
    logic                    div_by_zero;
    logic                    div_overflow;
    logic                    div_special;
    logic [WORD_WIDTH-1:0]   special_result;

    logic signed [2*WORD_WIDTH-1:0] mul_a;
    logic signed [2*WORD_WIDTH-1:0] mul_b;
    logic signed [2*WORD_WIDTH-1:0] product;
    logic [WORD_WIDTH-1:0]          mul_result;
    logic [WORD_WIDTH-1:0]          fix_result;

    logic [WORD_WIDTH-1:0]   rem_next;
    logic [WORD_WIDTH-1:0]   quo_next;

    // Two's-complement negate when the flag is set; used both to take
    // operand magnitudes and to restore result signs.
    function automatic logic [WORD_WIDTH-1:0] apply_sign(
        input logic [WORD_WIDTH-1:0] value,
        input logic                  neg
    );
        return neg ? (~value + 1'b1) : value;
    endfunction

    assign op_ready_o     = (state_q == IDLE);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;

    // Kill in IDLE blocks acceptance on that edge.
    assign accept        = op_valid_i && (state_q == IDLE) && !kill_i;
    assign is_div_op     = mdu_op_i[2];
    assign is_signed_div = (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_REM);
    assign div_by_zero   = (operand_b_i == '0);
    assign div_overflow  = is_signed_div
                           && (operand_a_i == {1'b1, {(WORD_WIDTH-1){1'b0}}})
                           && (operand_b_i == '1);
    assign div_special   = div_by_zero || div_overflow;

    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = mdu_op_i[1] ? operand_a_i : '1;
        end else if (div_overflow) begin
            special_result = mdu_op_i[1] ? '0 : operand_a_i;
        end
    end

    // Multiplier: operands sign- or zero-extended to the full product width
    // so a single signed multiply covers all four variants.
    always_comb begin
        mul_a      = {{WORD_WIDTH{((op_q == MDU_MULH) || (op_q == MDU_MULHSU)) & a_q[WORD_WIDTH-1]}}, a_q};
        mul_b      = {{WORD_WIDTH{(op_q == MDU_MULH) & b_q[WORD_WIDTH-1]}}, b_q};
        product    = mul_a * mul_b;
        mul_result = (op_q == MDU_MUL) ? product[WORD_WIDTH-1:0]
                                       : product[2*WORD_WIDTH-1:WORD_WIDTH];
    end

    // Sign flags are only set for DIV/REM, so unsigned ops pass through.
    always_comb begin
        if (op_q[1]) begin
            fix_result = apply_sign(rem_q, sign_a_q);
        end else begin
            fix_result = apply_sign(quo_q, sign_a_q ^ sign_b_q);
        end
    end

    riscv_mdu_div_step u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (b_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_div_op) begin
                        state_d = MUL;
                    end else if (div_special) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                state_d = kill_i ? IDLE : DONE;
            end
            DIV: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = kill_i ? IDLE : DONE;
            end
            DONE: begin
                if (kill_i || result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath. Result writes are suppressed under kill so result_o is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q <= mdu_op_i;
                if (!is_div_op) begin
                    a_q <= operand_a_i;
                    b_q <= operand_b_i;
                end else if (div_special) begin
                    result_q <= special_result;
                end else begin
                    sign_a_q <= is_signed_div & operand_a_i[WORD_WIDTH-1];
                    sign_b_q <= is_signed_div & operand_b_i[WORD_WIDTH-1];
                    quo_q    <= apply_sign(operand_a_i, is_signed_div & operand_a_i[WORD_WIDTH-1]);
                    b_q      <= apply_sign(operand_b_i, is_signed_div & operand_b_i[WORD_WIDTH-1]);
                    rem_q    <= '0;
                    cnt_q    <= CNT_W'(DIV_CYCLES);
                end
            end else begin
                unique case (state_q)
                    MUL: begin
                        if (!kill_i) begin
                            result_q <= mul_result;
                        end
                    end
                    DIV: begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    FIX: begin
                        if (!kill_i) begin
                            result_q <= fix_result;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_mdu.sv
module tb_riscv_mdu;
    import riscv_defines::*;

    logic                    clk;
    logic                    rst_n;
    logic                    op_valid_i;
    logic                    op_ready_o;
    logic [MDU_OP_WIDTH-1:0] mdu_op_i;
    logic [WORD_WIDTH-1:0]   operand_a_i;
    logic [WORD_WIDTH-1:0]   operand_b_i;
    logic                    kill_i;
    logic                    result_valid_o;
    logic                    result_ready_i;
    logic [WORD_WIDTH-1:0]   result_o;

    int checks   = 0;
    int failures = 0;

    riscv_mdu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid_i     (op_valid_i),
        .op_ready_o     (op_ready_o),
        .mdu_op_i       (mdu_op_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .kill_i         (kill_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_valid_i  = 1'b1;
        mdu_op_i    = op;
        operand_a_i = a;
        operand_b_i = b;
        @(posedge clk);
        #1;
        op_valid_i  = 1'b0;
        operand_a_i = 32'hDEAD_BEEF;
        operand_b_i = 32'h0BAD_F00D;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!result_valid_o && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!result_valid_o) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic consume(input string tag);
        result_ready_i = 1'b1;
        @(posedge clk);
        #1;
        result_ready_i = 1'b0;
        check({tag, "_ready_after"}, {31'd0, op_ready_o}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int cyc;
        issue(op, a, b);
        wait_valid(tag, cyc);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_latency"}, cyc, exp_cyc);
        consume(tag);
    endtask

    initial begin
        int pulses;
        rst_n          = 1'b0;
        op_valid_i     = 1'b0;
        mdu_op_i       = MDU_MUL;
        operand_a_i    = '0;
        operand_b_i    = '0;
        kill_i         = 1'b0;
        result_ready_i = 1'b0;
        #12;
        check("rst_ready", {31'd0, op_ready_o}, 32'd1);
        check("rst_valid", {31'd0, result_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul_7x6", MDU_MUL, 32'd7, 32'd6, 32'd42, 1);

        // Asynchronous reset in the middle of a divide
        issue(MDU_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, op_ready_o}, 32'd1);
        check("midrst_valid", {31'd0, result_valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mulh",   MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("mulhu",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run_op("mul_lo", MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);

        run_op("div_m7_2",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",  MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", MDU_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_7_m2",  MDU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",  MDU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        run_op("divu_by0", MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_by0", MDU_REMU, 32'd5, 32'd0, 32'd5, 0);
        run_op("div_ovf",  MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",  MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // Backpressure: result held, new requests ignored
        begin
            int cyc;
            issue(MDU_MUL, 32'd5, 32'd5);
            wait_valid("bp", cyc);
            op_valid_i  = 1'b1;
            mdu_op_i    = MDU_DIVU;
            operand_a_i = 32'd1;
            operand_b_i = 32'd1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                check("bp_result", result_o, 32'd25);
                check("bp_ready", {31'd0, op_ready_o}, 32'd0);
                check("bp_valid", {31'd0, result_valid_o}, 32'd1);
            end
            op_valid_i = 1'b0;
            consume("bp");
            check("bp_valid_after", {31'd0, result_valid_o}, 32'd0);
            @(posedge clk);
            #1;
            check("bp_no_accept", {31'd0, op_ready_o}, 32'd1);
        end

        // Kill during divide iteration 10
        issue(MDU_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        check("kill_ready", {31'd0, op_ready_o}, 32'd1);
        check("kill_valid", {31'd0, result_valid_o}, 32'd0);
        check("kill_result_held", result_o, 32'd25);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (result_valid_o) pulses++;
        end
        check("kill_no_pulse", pulses, 32'd0);

        // Kill in IDLE blocks acceptance
        kill_i      = 1'b1;
        op_valid_i  = 1'b1;
        mdu_op_i    = MDU_MUL;
        operand_a_i = 32'd2;
        operand_b_i = 32'd2;
        @(posedge clk);
        #1;
        kill_i     = 1'b0;
        op_valid_i = 1'b0;
        check("kill_idle_ready", {31'd0, op_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        check("kill_idle_valid", {31'd0, result_valid_o}, 32'd0);

        run_op("mul_3x3", MDU_MUL, 32'd3, 32'd3, 32'd9, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/riscv_mdu.md
Name: riscv_mdu

Overview:
- Execution-stage multiply/divide responder for the RV32M extension.
- Accepts one MDU operation per request handshake, with the operation coded per the shared MDU_* constants (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Returns the 32-bit result over a valid/ready result handshake.
- Multiplies complete in a single compute cycle. Divides and remainders use an iterative restoring divider (one quotient bit per cycle) with RISC-V special-case handling.
- Instantiated only when RISCV_M_CORE = 1.

Parameters:
- WORD_WIDTH, 32, operand/result width (from the shared package).
- MDU_OP_WIDTH, 3, op code width (from the shared package).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid_i  in  1  request valid.
- op_ready_o  out  1  block can accept a request; equals (state == IDLE).
- mdu_op_i  in  MDU_OP_WIDTH  operation code.
- operand_a_i  in  WORD_WIDTH  rs1 value (multiplicand / dividend).
- operand_b_i  in  WORD_WIDTH  rs2 value (multiplier / divisor).
- kill_i  in  1  synchronous abort (pipeline flush).
- result_valid_o  out  1  result available; equals (state == DONE).
- result_ready_i  in  1  consumer takes the result.
- result_o  out  WORD_WIDTH  registered result, stable while result_valid_o = 1.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, so op_ready_o = 1 and result_valid_o = 0.
  - result_o = 0, iteration counter = 0, internal operand/remainder/quotient registers = 0.
- Accept: op_valid_i && op_ready_o sampled at edge E0. Operands, op and sign flags are latched at E0; input ports are ignored after E0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - On accept of MUL/MULH/MULHSU/MULHU, go to MUL.
  - On accept of DIV/DIVU/REM/REMU:
    - Special case, go straight to DONE with result_o loaded at E0:
      - divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
      - signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
    - Otherwise go to DIV: take magnitudes of the operands for signed ops, counter = 32, remainder = 0.
- MUL (one cycle):
  - 33x33 signed product of sign/zero-extended operands.
  - Extension: MULH signed x signed, MULHSU signed x unsigned, MULHU and MUL unsigned.
  - MUL writes product[31:0]; the others write product[63:32].
  - Go to DONE at E1; result_valid_o = 1 during cycle 2.
- DIV (32 cycles):
  - Each cycle: shift {rem, quo} left by 1; if rem >= |b|, subtract and set the quotient LSB.
  - Counter decrements; leave for FIX when the counter reaches 1 → 0.
- FIX (one cycle):
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a), applied only for signed ops.
  - Write quotient (DIV/DIVU) or remainder (REM/REMU) to result_o.
  - Go to DONE.
- Divide latency: accept at E0, DONE after E33, result_valid_o high in cycle 34.
- DONE:
  - Hold result_o and result_valid_o until result_ready_i = 1.
  - On handshake edge, go to IDLE; a new request cannot be accepted on that same edge. Best-case throughput is one op per 3 cycles.
- kill_i:
  - In MUL/DIV/FIX/DONE: go to IDLE at the next edge; no result is delivered; result_o is held (no clear).
  - kill_i in IDLE blocks acceptance on that edge.
  - kill_i takes priority over result_ready_i.
- Reset mid-operation: immediate return to reset values; partial results are discarded.
- Undefined op codes: none; all 8 codes are legal.

Decomposition:
- Shared package (riscv_defines) holds:
  - MDU_* op codes and MDU_OP_WIDTH, reused.
  - New typedef mdu_state_t enum {IDLE, MUL, DIV, FIX, DONE}.
  - DIV_CYCLES = WORD_WIDTH.
- One sub-module, riscv_mdu_div_step: the combinational restoring step (rem, quo, divisor in; rem', quo' out). It keeps the iterate datapath testable in isolation.
- The multiplier is inline.

Test Plan:
- Reset and handshake: assert rst_n = 0 mid-DIV → op_ready_o = 1, result_valid_o = 0, result_o = 0 immediately. Then MUL 7 x 6 → result_o = 42, result_valid_o high 2 cycles after accept.
- High-word multiplies:
  - MULH 0x80000000 x 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide: DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14. result_valid_o rises exactly 34 cycles after accept.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0.
  - Each of these valid 1 cycle after accept.
- Backpressure: hold result_ready_i = 0 for 10 cycles after DONE → result_o stable, op_ready_o = 0, new op_valid_i ignored. On release, IDLE next cycle.
- Kill: kill_i at iteration 10 of DIVU 100 / 7 → IDLE next cycle, no result_valid_o pulse. A following MUL 3 x 3 returns 9.
